// File: rtl/param_loader.sv
// ============================================================================
// Module   : param_loader
// Purpose  : Loads NUM_PARAMS words from a valid/ready stream into the
//            parameter memory, then serves indexed reads. It hides the
//            memory's one-cycle synchronous read latency.
// Options  : PARAM_CHECKSUM_EN - after the last word, accept one trailing
//            checksum word and accept the load only if it matches.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_loader #(
   parameter int DATA_SIZE  = 16,
   parameter int MEM_SIZE   = 4,
   parameter int NUM_PARAMS = 13
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATA_SIZE-1:0] in_data,
   input  logic                 rd_req,
   output logic                 rd_ready,
   input  logic [MEM_SIZE-1:0]  rd_idx,
   output logic                 rd_valid,
   output logic [DATA_SIZE-1:0] rd_data,
   output logic                 rd_err,
   output logic                 loaded,
   output logic                 load_err,
   output logic [MEM_SIZE-1:0]  mem_ad,
   output logic                 mem_we,
   output logic [DATA_SIZE-1:0] mem_wd,
   input  logic [DATA_SIZE-1:0] mem_rd
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
`ifdef PARAM_CHECKSUM_EN
      S_CSUM  = 3'd2,
`endif
      S_READY = 3'd3,
      S_FETCH = 3'd4,
      S_WAIT  = 3'd5
   } state_t;

   localparam logic [MEM_SIZE-1:0] c_LAST_IDX  = MEM_SIZE'(NUM_PARAMS - 1);
   // One extra bit so NUM_PARAMS == 2**MEM_SIZE still compares correctly.
   localparam logic [MEM_SIZE:0]   c_IDX_LIMIT = (MEM_SIZE + 1)'(NUM_PARAMS);

   state_t              r_state;
   state_t              w_state_next;
   logic [MEM_SIZE-1:0] r_wcnt;
   logic                r_pend_err;
   logic                w_hs;
   logic                w_last;
   logic                w_idx_ok;
`ifdef PARAM_CHECKSUM_EN
   logic [DATA_SIZE-1:0] r_acc;
   logic                 w_csum_ok;
   assign w_csum_ok = (in_data == r_acc);
`else
   assign load_err = 1'b0;
`endif

   assign in_ready = (r_state == S_LOAD)
`ifdef PARAM_CHECKSUM_EN
                     || (r_state == S_CSUM)
`endif
                     ;
   assign rd_ready = (r_state == S_READY);
   assign w_hs     = in_valid && in_ready;
   assign w_last   = (r_wcnt == c_LAST_IDX);
   assign w_idx_ok = ({1'b0, rd_idx} < c_IDX_LIMIT);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   // Next-state logic; start takes priority over a read request in READY.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_next = S_LOAD;
         S_LOAD: begin
            if (w_hs && w_last) begin
`ifdef PARAM_CHECKSUM_EN
               w_state_next = S_CSUM;
`else
               w_state_next = S_READY;
`endif
            end
         end
`ifdef PARAM_CHECKSUM_EN
         S_CSUM:  if (w_hs) w_state_next = w_csum_ok ? S_READY : S_IDLE;
`endif
         S_READY: begin
            if (start)       w_state_next = S_LOAD;
            else if (rd_req) w_state_next = w_idx_ok ? S_FETCH : S_WAIT;
         end
         S_FETCH: w_state_next = S_WAIT;
         S_WAIT:  w_state_next = S_READY;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Datapath: memory port, write counter, status flags and read result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wcnt     <= '0;
         r_pend_err <= 1'b0;
         loaded     <= 1'b0;
         mem_ad     <= '0;
         mem_we     <= 1'b0;
         mem_wd     <= '0;
         rd_valid   <= 1'b0;
         rd_data    <= '0;
         rd_err     <= 1'b0;
`ifdef PARAM_CHECKSUM_EN
         r_acc      <= '0;
         load_err   <= 1'b0;
`endif
      end else begin
         mem_we   <= 1'b0;
         rd_valid <= 1'b0;
         case (r_state)
            S_IDLE, S_READY: begin
               if (start) begin
                  r_wcnt <= '0;
                  loaded <= 1'b0;
`ifdef PARAM_CHECKSUM_EN
                  r_acc    <= '0;
                  load_err <= 1'b0;
`endif
               end else if ((r_state == S_READY) && rd_req) begin
                  // Out-of-range indices never touch the memory address.
                  if (w_idx_ok) mem_ad <= rd_idx;
                  r_pend_err <= !w_idx_ok;
               end
            end
            S_LOAD: begin
               if (w_hs) begin
                  mem_ad <= r_wcnt;
                  mem_wd <= in_data;
                  mem_we <= 1'b1;
                  r_wcnt <= r_wcnt + MEM_SIZE'(1);
`ifdef PARAM_CHECKSUM_EN
                  r_acc  <= r_acc + in_data;
`else
                  if (w_last) loaded <= 1'b1;
`endif
               end
            end
`ifdef PARAM_CHECKSUM_EN
            S_CSUM: begin
               if (w_hs) begin
                  if (w_csum_ok) loaded   <= 1'b1;
                  else           load_err <= 1'b1;
               end
            end
`endif
            S_WAIT: begin
               rd_valid <= 1'b1;
               rd_err   <= r_pend_err;
               rd_data  <= r_pend_err ? '0 : mem_rd;
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_param_loader.sv
// ============================================================================
// Module   : tb_param_loader
// Purpose  : Directed self-checking bench for param_loader with a
//            behavioural synchronous parameter memory attached.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_param_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = '0;
   logic        rd_req = 1'b0;
   logic        rd_ready;
   logic [3:0]  rd_idx = '0;
   logic        rd_valid;
   logic [15:0] rd_data;
   logic        rd_err;
   logic        loaded;
   logic        load_err;
   logic [3:0]  mem_ad;
   logic        mem_we;
   logic [15:0] mem_wd;
   logic [15:0] mem_rd;

   logic [15:0] mem [0:15];

   int total = 0;
   int bad   = 0;

   param_loader #(
      .DATA_SIZE (16),
      .MEM_SIZE  (4),
      .NUM_PARAMS(13)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data (in_data),
      .rd_req  (rd_req),
      .rd_ready(rd_ready),
      .rd_idx  (rd_idx),
      .rd_valid(rd_valid),
      .rd_data (rd_data),
      .rd_err  (rd_err),
      .loaded  (loaded),
      .load_err(load_err),
      .mem_ad  (mem_ad),
      .mem_we  (mem_we),
      .mem_wd  (mem_wd),
      .mem_rd  (mem_rd)
   );

   always #5 clk = ~clk;

   // Synchronous single-port parameter memory (read-before-write).
   always @(posedge clk) begin
      if (mem_we) mem[mem_ad] <= mem_wd;
      mem_rd <= mem[mem_ad];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Full load of base..base+12; optionally idle one cycle before each word.
   task automatic load_stream(input int base, input bit toggle);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("in_ready_load", {31'd0, in_ready}, 1);
      chk("loaded_clr", {31'd0, loaded}, 0);
      for (int i = 0; i < 13; i++) begin
         if (toggle) begin
            in_valid = 1'b0;
            tick();
            chk("stall_we", {31'd0, mem_we}, 0);
            if (i > 0) chk("stall_ad", {28'd0, mem_ad}, i - 1);
         end
         in_valid = 1'b1;
         in_data  = 16'(base + i);
         tick();
         chk("load_we", {31'd0, mem_we}, 1);
         chk("load_ad", {28'd0, mem_ad}, i);
         chk("load_wd", {16'd0, mem_wd}, base + i);
         if (i < 12) chk("loaded_early", {31'd0, loaded}, 0);
      end
`ifdef PARAM_CHECKSUM_EN
      chk("csum_wait", {31'd0, loaded}, 0);
      in_data = 16'(13 * base + 78);
      tick();
      chk("csum_we", {31'd0, mem_we}, 0);
`endif
      in_valid = 1'b0;
      chk("loaded", {31'd0, loaded}, 1);
      chk("rd_ready_after_load", {31'd0, rd_ready}, 1);
      chk("in_ready_after_load", {31'd0, in_ready}, 0);
      tick();
      chk("idle_we", {31'd0, mem_we}, 0);
   endtask

   // Issue one read; in-range results appear after the third edge, errors after the second.
   task automatic rd_chk(input string tag, input int idx, input int exp_d, input bit exp_e, input bit hold);
      rd_idx = 4'(idx);
      rd_req = 1'b1;
      tick();
      if (!hold) rd_req = 1'b0;
      chk({tag, "_v0"}, {31'd0, rd_valid}, 0);
      chk({tag, "_busy"}, {31'd0, rd_ready}, 0);
      if (!exp_e) begin
         tick();
         chk({tag, "_v1"}, {31'd0, rd_valid}, 0);
      end
      tick();
      chk({tag, "_valid"}, {31'd0, rd_valid}, 1);
      chk({tag, "_data"}, {16'd0, rd_data}, exp_d);
      chk({tag, "_err"}, {31'd0, rd_err}, {31'd0, exp_e});
      chk({tag, "_ready"}, {31'd0, rd_ready}, 1);
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      chk("rst_loaded", {31'd0, loaded}, 0);
      chk("rst_load_err", {31'd0, load_err}, 0);
      chk("rst_we", {31'd0, mem_we}, 0);
      chk("rst_ad", {28'd0, mem_ad}, 0);
      chk("rst_rd_valid", {31'd0, rd_valid}, 0);
      chk("rst_in_ready", {31'd0, in_ready}, 0);
      chk("rst_rd_ready", {31'd0, rd_ready}, 0);
      rst = 1'b0;
      tick();
      chk("idle_in_ready", {31'd0, in_ready}, 0);

      // Streamed load 100..112, then reads
      load_stream(100, 1'b0);
      rd_chk("rd5", 5, 105, 1'b0, 1'b0);
      tick();
      chk("rd_pulse_end", {31'd0, rd_valid}, 0);
      chk("rd_data_hold", {16'd0, rd_data}, 105);
      rd_chk("rd0", 0, 100, 1'b0, 1'b1);
      rd_chk("rd12", 12, 112, 1'b0, 1'b0);

      // Out-of-range indices
      rd_chk("rd13", 13, 0, 1'b1, 1'b0);
      chk("rd13_ad", {28'd0, mem_ad}, 12);
      rd_chk("rd15", 15, 0, 1'b1, 1'b0);
      chk("rd15_ad", {28'd0, mem_ad}, 12);
      rd_chk("rd7", 7, 107, 1'b0, 1'b0);

      // Load with valid toggling, full read-back
      load_stream(300, 1'b1);
      for (int i = 0; i < 13; i++) rd_chk("rb", i, 300 + i, 1'b0, 1'b0);

      // Reset in the middle of a load, then reload
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         in_data  = 16'(50 + i);
         tick();
      end
      chk("mid_we", {31'd0, mem_we}, 1);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("mid_rst_we", {31'd0, mem_we}, 0);
      chk("mid_rst_loaded", {31'd0, loaded}, 0);
      chk("mid_rst_in_ready", {31'd0, in_ready}, 0);
      chk("mid_rst_ad", {28'd0, mem_ad}, 0);
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst_loaded", {31'd0, loaded}, 0);
      load_stream(200, 1'b0);
      rd_chk("rd3", 3, 203, 1'b0, 1'b0);

`ifdef PARAM_CHECKSUM_EN
      // Good checksum: 1..13 sums to 91
      load_stream(1, 1'b0);
      rd_chk("cs_rd4", 4, 5, 1'b0, 1'b0);
      // Bad checksum: 90
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 13; i++) begin
         in_valid = 1'b1;
         in_data  = 16'(1 + i);
         tick();
      end
      in_data = 16'd90;
      tick();
      in_valid = 1'b0;
      chk("cs_bad_err", {31'd0, load_err}, 1);
      chk("cs_bad_loaded", {31'd0, loaded}, 0);
      chk("cs_bad_rd_ready", {31'd0, rd_ready}, 0);
      chk("cs_bad_in_ready", {31'd0, in_ready}, 0);
      rd_idx = 4'd2;
      rd_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("cs_bad_no_read", {31'd0, rd_valid}, 0);
      end
      rd_req = 1'b0;
      tick();
      chk("cs_bad_sticky", {31'd0, load_err}, 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
